// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: digit count, blank pattern, glyph table.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD/hex nibble to active-low seven-segment glyph.
// Purely combinational.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = GLYPHS[bcd];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode scan driver with
// per-frame snapshot, leading-zero blanking and blink.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DWELL_CYCLES = 12500,
    parameter int GUARD_CYCLES = 250,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_in,
    input  logic [3:0] blink_mask,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [DW-1:0]       dwell;
    logic [1:0]          idx;
    logic [BW-1:0]       bcnt;
    logic                phase;
    logic [3:0][3:0]     s_d;
    logic [3:0]          s_dp;
    logic [3:0]          s_mask;
    logic                s_lz;

    logic                dwell_wrap;
    logic                frame_wrap;
    logic                blink_wrap;
    logic [3:0]          cur;
    logic [6:0]          glyph;
    logic                lz1, lz2, lz3;
    logic                lzb;
    logic                blank;
    logic [3:0]          an_n;
    logic [6:0]          seg_n;
    logic                dp_n;

    assign dwell_wrap = (dwell == DW'(DWELL_CYCLES - 1));
    assign frame_wrap = dwell_wrap && (idx == 2'd3);
    assign blink_wrap = (bcnt == BW'(BLINK_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell <= '0;
            idx   <= '0;
        end else begin
            dwell <= dwell_wrap ? '0 : dwell + 1'b1;
            if (dwell_wrap)
                idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            bcnt <= blink_wrap ? '0 : bcnt + 1'b1;
            if (blink_wrap)
                phase <= ~phase;
        end
    end

    // Snapshot only at the frame boundary so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_d    <= '0;
            s_dp   <= '0;
            s_mask <= '0;
            s_lz   <= 1'b0;
        end else if (frame_wrap) begin
            s_d    <= {digit3, digit2, digit1, digit0};
            s_dp   <= dp_in;
            s_mask <= blink_mask;
            s_lz   <= blank_lz;
        end
    end

    assign cur = s_d[idx];

    bcd_to_seg7 u_dec (
        .bcd (cur),
        .seg (glyph)
    );

    always_comb begin
        lz3 = s_lz && (s_d[3] == 4'd0);
        lz2 = lz3 && (s_d[2] == 4'd0);
        lz1 = lz2 && (s_d[1] == 4'd0);
        lzb = 1'b0;
        unique case (idx)
            2'd0: lzb = 1'b0;
            2'd1: lzb = lz1;
            2'd2: lzb = lz2;
            2'd3: lzb = lz3;
        endcase
        blank = lzb | (phase & s_mask[idx]);
        seg_n = blank ? SEG_BLANK : glyph;
        dp_n  = blank | ~s_dp[idx];
        an_n  = ~(4'b0001 << idx);
        if (dwell < DW'(GUARD_CYCLES))
            an_n = 4'b1111;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_n;
            seg         <= seg_n;
            dp          <= dp_n;
            frame_start <= frame_wrap;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes the four 4-bit BCD digits produced by the time counter stage.
- Drives the board's 4-digit, common-anode, multiplexed seven-segment display: time-division digit scan, BCD-to-segment decode, leading-zero blanking and per-digit blink for time-set mode.
- Inputs are snapshotted once per frame so a counter carry never tears a displayed frame.

Parameters:
- DWELL_CYCLES, 12500, clock cycles each digit is selected (50 MHz / 4 kHz); minimum 2.
- GUARD_CYCLES, 250, cycles at the start of each dwell with all anodes off (anti-ghosting); must be < DWELL_CYCLES.
- BLINK_CYCLES, 25000000, cycles per blink half-period (0.5 s at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- digit0  in  4  least significant digit (rightmost), BCD/hex.
- digit1  in  4  digit 1.
- digit2  in  4  digit 2.
- digit3  in  4  most significant digit (leftmost).
- dp_in  in  4  decimal point request per digit, bit i = digit i, 1 = lit.
- blink_mask  in  4  bit i = 1 blinks digit i.
- blank_lz  in  1  1 = suppress leading zeros on digits 3..1.
- an  out  4  anode enables, active-low, an[i] = digit i.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when the snapshot loads.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-frame):
  - an=4'b1111, seg=7'h7F, dp=1, frame_start=0.
  - Dwell counter=0, scan index=0, blink phase=0 (visible), snapshot digits/dp/mask/lz=0.
- Dwell counter counts 0..DWELL_CYCLES-1 and wraps.
- At wrap the scan index advances 0→1→2→3→0.
- Snapshot: on the clock edge where the index wraps 3→0, all inputs are registered and frame_start=1 for that one cycle. Inputs outside that edge are ignored.
- The first frame after reset displays the reset snapshot: all digits 0 with blank_lz=0, so "0000" shows.
- Output registers are updated every cycle from the current index, dwell count and snapshot, giving 1-cycle latency from index change to an/seg/dp change.
- Guard interval: while dwell count < GUARD_CYCLES, an=4'b1111. Otherwise an = ~(1<<index).
  - seg/dp may change during the guard and must be valid before the anode asserts.
- Decode: 0..9 use standard glyphs, with 0=7'h40, 1=7'h79, 5=7'h12, 8=7'h00. 10..15 show hex A,b,C,d,E,F, with A=7'h08 and F=7'h0E.
- Leading-zero blanking (snapshot blank_lz=1):
  - digit3 is blanked if it is 0.
  - digit2 is blanked if digit3 and digit2 are both 0.
  - digit1 is blanked if digits 3..1 are all 0.
  - digit0 is never blanked.
  - A blanked digit gives seg=7'h7F and dp=1; the anode still scans.
- Blink: a free-running counter toggles the blink phase every BLINK_CYCLES. While phase=1, digits with their snapshot mask bit set give seg=7'h7F and dp=1.
- Blink and leading-zero blanking are ORed. The dp of a non-blanked digit follows the snapshot dp_in bit (dp = ~bit).
- All counters wrap freely and none saturates.

Decomposition:
- Shared package seg7_pkg:
  - Glyph constants SEG_BLANK=7'h7F and the 16-entry glyph table.
  - Constant NUM_DIGITS=4.
- One combinational sub-module bcd_to_seg7 (4-bit in, 7-bit active-low out), reused by later display blocks.

Test Plan (DWELL_CYCLES=4, GUARD_CYCLES=1, BLINK_CYCLES=32):
1. Reset: assert rst mid-dwell → an=1111, seg=7F and dp=1 immediately. After release, the first selected digit shows an=1110 with seg=7'h40.
2. Digits 1,2,3,4 (digit3..0), held across a snapshot edge, no blank/blink → the scan sequence shows:
   - an 1110 with seg=7'h19, then 1101 with 7'h30, then 1011 with 7'h24, then 0111 with 7'h79.
   - Each digit is preceded by 1 guard cycle of an=1111.
   - frame_start pulses once every 16 cycles.
3. Digits 0,0,0,7 with blank_lz=1 → digits 3..1 show seg=7F with their anodes still scanning; digit0 shows 7'h78. With 0,1,0,7 only digit3 is blanked.
4. Input changes from 0,0,0,9 to 0,0,1,0 mid-frame → the displayed value changes only after the next frame_start; no frame mixes old and new digits.
5. blink_mask=4'b0011, dp_in=4'b0100 → digits 1,0 show 7F for 32 cycles and normal glyphs for the next 32. digit2 always has dp=0; all others have dp=1.
6. Digit value 4'hA → seg=7'h08; digit value 4'hF → seg=7'h0E. Both are unaffected by blank_lz.
